// File: rtl/clkbuf_branch_sequencer.sv
// clkbuf_branch_sequencer
// Staggers ICG enable changes for NBR gated clock-tree branches so that at most one branch
// switches per settle window. Each branch uses a level REQ/ACK handshake. Simultaneous
// requests are serialised round-robin.
//
// Ports:
//   CLK   always-on sequencer clock
//   RST   asynchronous active-high reset (all branches gated off immediately)
//   REQ   per-branch request level (1 = clock on, 0 = clock off)
//   LOCK  freeze new grants while high (only when CLKSEQ_LOCK_EN is defined)
//   EN    per-branch ICG enable, registered
//   ACK   per-branch acknowledged state, equals EN once the branch has settled
//   BUSY  high while a transition is settling
//
// Optional feature macro: CLKSEQ_LOCK_EN adds the LOCK input. Without it the block behaves
// as if LOCK were tied low.
module clkbuf_branch_sequencer #(
  parameter int unsigned NBR    = 4,
  parameter int unsigned SETTLE = 3,
  parameter int unsigned CNTW   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NBR-1:0] REQ,
`ifdef CLKSEQ_LOCK_EN
  input  logic           LOCK,
`endif
  output logic [NBR-1:0] EN,
  output logic [NBR-1:0] ACK,
  output logic           BUSY
);

  localparam int unsigned PtrW = (NBR > 1) ? $clog2(NBR) : 1;

  typedef enum logic [0:0] {StIdle, StSettle} state_e;

  state_e         state_q, state_d;
  logic [NBR-1:0] en_q, en_d;
  logic [NBR-1:0] ack_q, ack_d;
  logic           busy_q, busy_d;
  logic [PtrW-1:0] rr_q, rr_d;
  logic [PtrW-1:0] gnt_q, gnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NBR-1:0]  pending;
  logic            lock;
  logic            gnt_found;
  logic [PtrW-1:0] gnt_idx;

`ifdef CLKSEQ_LOCK_EN
  assign lock = LOCK;
`else
  assign lock = 1'b0;
`endif

  // A branch needs service whenever its request differs from what has been acknowledged.
  assign pending = REQ ^ ack_q;

  // Round-robin pick: first pending index at or after the pointer, wrapping modulo NBR.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NBR; k++) begin
      idx = (32'(rr_q) + k) % NBR;
      if (!gnt_found && pending[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (gnt_found && !lock) begin
          en_d[gnt_idx] = REQ[gnt_idx];
          gnt_d         = gnt_idx;
          cnt_d         = CNTW'(SETTLE);
          busy_d        = 1'b1;
          state_d       = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CNTW'(1)) begin
          // ACK takes the value actually driven, even if REQ has already moved on;
          // the branch then simply shows up as pending again.
          ack_d[gnt_q] = en_q[gnt_q];
          busy_d       = 1'b0;
          rr_d         = (32'(gnt_q) == NBR - 1) ? '0 : gnt_q + PtrW'(1);
          cnt_d        = '0;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      en_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EN   = en_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_clkbuf_branch_sequencer.sv
// Testbench for clkbuf_branch_sequencer: transaction-level reference model feeding an
// expected-event scoreboard; a negedge monitor pops and compares every EN/ACK change.
module tb_clkbuf_branch_sequencer;

  localparam int NBR    = 4;
  localparam int SETTLE = 3;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [NBR-1:0] req = '0;
  logic           lock = 1'b0;
  logic [NBR-1:0] EN;
  logic [NBR-1:0] ACK;
  logic           BUSY;

  always #5 CLK = ~CLK;

  clkbuf_branch_sequencer #(
    .NBR   (NBR),
    .SETTLE(SETTLE),
    .CNTW  (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .REQ (req),
`ifdef CLKSEQ_LOCK_EN
    .LOCK(lock),
`endif
    .EN  (EN),
    .ACK (ACK),
    .BUSY(BUSY)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int grants = 0;

  typedef struct {
    int g;
    int v;
    int en_c;
    int ack_c;
  } ev_t;

  ev_t enq[$];
  ev_t ackq[$];

  // Reference model state: acknowledged levels, rr pointer, one outstanding transition.
  bit m_ack[NBR];
  int m_rr;
  int m_busy;
  int m_ack_at;
  int m_ack_g;
  int m_ack_v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a grant may happen at any IDLE edge; its ACK lands SETTLE edges later and the
  // next grant is possible on the edge after that.
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      for (int i = 0; i < NBR; i++) m_ack[i] = 1'b0;
      m_rr   = 0;
      m_busy = 0;
      enq.delete();
      ackq.delete();
    end else if (m_busy != 0) begin
      if (cyc == m_ack_at) begin
        m_ack[m_ack_g] = m_ack_v[0];
        m_busy = 0;
        m_rr   = (m_ack_g + 1) % NBR;
      end
    end else if (!lock) begin
      int g;
      int i;
      ev_t e;
      g = -1;
      for (int k = 0; k < NBR; k++) begin
        i = (m_rr + k) % NBR;
        if (g < 0 && req[i] != m_ack[i]) g = i;
      end
      if (g >= 0) begin
        e.g     = g;
        e.v     = int'(req[g]);
        e.en_c  = cyc;
        e.ack_c = cyc + SETTLE;
        enq.push_back(e);
        m_busy   = 1;
        m_ack_at = cyc + SETTLE;
        m_ack_g  = g;
        m_ack_v  = int'(req[g]);
      end
    end
  end

  logic [NBR-1:0] prev_en  = '0;
  logic [NBR-1:0] prev_ack = '0;

  always @(negedge CLK) begin
    if (RST) begin
      prev_en  = EN;
      prev_ack = ACK;
    end else begin
      logic [NBR-1:0] diff;
      int idx;
      ev_t e;
      chk("busy", int'(BUSY), m_busy);
      diff = EN ^ prev_en;
      if (diff != '0) begin
        grants++;
        idx = -1;
        for (int i = 0; i < NBR; i++) if (idx < 0 && diff[i]) idx = i;
        chk("en_onehot", $countones(diff), 1);
        if (enq.size() == 0) begin
          chk("en_unexpected", idx, -1);
        end else begin
          e = enq.pop_front();
          chk("en_branch", idx, e.g);
          chk("en_value", int'(EN[e.g]), e.v);
          chk("en_cycle", cyc, e.en_c);
          ackq.push_back(e);
        end
      end else if (enq.size() > 0 && enq[0].en_c < cyc) begin
        e = enq.pop_front();
        chk("en_missing", -1, e.g);
      end
      diff = ACK ^ prev_ack;
      if (diff != '0) begin
        idx = -1;
        for (int i = 0; i < NBR; i++) if (idx < 0 && diff[i]) idx = i;
        chk("ack_onehot", $countones(diff), 1);
        if (ackq.size() == 0) begin
          chk("ack_unexpected", idx, -1);
        end else begin
          e = ackq.pop_front();
          chk("ack_branch", idx, e.g);
          chk("ack_value", int'(ACK[e.g]), e.v);
          chk("ack_cycle", cyc, e.ack_c);
        end
      end else if (ackq.size() > 0 && ackq[0].ack_c < cyc) begin
        e = ackq.pop_front();
        chk("ack_missing", -1, e.g);
      end
      prev_en  = EN;
      prev_ack = ACK;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    #1 RST = 1'b1;
    req  = '0;
    lock = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic wait_en(input logic [NBR-1:0] want, input int maxc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (EN == want) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  localparam int Drain = NBR * (SETTLE + 1) + 8;

  initial begin
    int g0;
    #1 RST = 1'b1;
    #2;
    chk("rst_en", int'(EN), 0);
    chk("rst_ack", int'(ACK), 0);
    chk("rst_busy", int'(BUSY), 0);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;

    // Single branch on.
    @(negedge CLK);
    req = 4'b0001;
    repeat (Drain) @(negedge CLK);
    chk("single_ack", int'(ACK), 1);
    chk("single_en", int'(EN), 1);

    // All branches on from reset, then all off.
    do_reset();
    req = 4'b1111;
    repeat (Drain) @(negedge CLK);
    chk("all_on_ack", int'(ACK), 15);
    req = 4'b0000;
    repeat (Drain) @(negedge CLK);
    chk("all_off_ack", int'(ACK), 0);
    chk("all_off_en", int'(EN), 0);

    // Request withdrawn during SETTLE: transition completes, then reverts.
    g0 = grants;
    req = 4'b0100;
    wait_en(4'b0100, 20, "wait_en2");
    @(negedge CLK);
    req = 4'b0000;
    repeat (Drain) @(negedge CLK);
    chk("revert_grants", grants - g0, 2);
    chk("revert_ack", int'(ACK), 0);
    chk("revert_en", int'(EN), 0);

    // Asynchronous reset in the middle of a settle window.
    do_reset();
    req = 4'b0111;
    wait_en(4'b0111, 40, "wait_en7");
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_en", int'(EN), 0);
    chk("async_rst_ack", int'(ACK), 0);
    chk("async_rst_busy", int'(BUSY), 0);
    req = '0;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;

`ifdef CLKSEQ_LOCK_EN
    lock = 1'b1;
    req  = 4'b0011;
    repeat (10) @(negedge CLK);
    chk("lock_en", int'(EN), 0);
    lock = 1'b0;
    repeat (Drain) @(negedge CLK);
    chk("unlock_ack", int'(ACK), 3);
    req = '0;
    repeat (Drain) @(negedge CLK);
`endif

    // Random request toggling, including short glitches.
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NBR - 1)] ^= 1'b1;
    end
    repeat (Drain) @(negedge CLK);
    chk("rand_ack", int'(ACK), int'(req));
    chk("rand_en", int'(EN), int'(req));
    chk("rand_busy", int'(BUSY), 0);
    chk("enq_empty", enq.size(), 0);
    chk("ackq_empty", ackq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
